// File: rtl/seg_scan_decoder.sv
// Rebuilds the hex nibbles shown on a multiplexed active-low 7-segment bus.
// Build option: define SEG_SCAN_BLANK_EN to accept the all-off pattern as a legal blank.
module seg_scan_decoder #(
   parameter  int N_DIG       = 4,
   parameter  int SETTLE_CYC  = 4,
   parameter  int TIMEOUT_CYC = 1000000,
   localparam int IDX_W       = (N_DIG > 2) ? $clog2(N_DIG) : 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [6:0]           seg_led,
   input  logic [N_DIG-1:0]     seg_sel,
   output logic [4*N_DIG-1:0]   hex_data,
   output logic [N_DIG-1:0]     digit_valid,
   output logic                 upd_stb,
   output logic [IDX_W-1:0]     upd_idx,
   output logic                 pat_err,
   output logic                 sel_err
);

   localparam int PAIR_W = N_DIG + 7;
   localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

   // {legal, nibble} for an active-low gfedcba pattern
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      case (seg)
         7'b1000000: seg_decode = {1'b1, 4'h0};
         7'b1111001: seg_decode = {1'b1, 4'h1};
         7'b0100100: seg_decode = {1'b1, 4'h2};
         7'b0110000: seg_decode = {1'b1, 4'h3};
         7'b0011001: seg_decode = {1'b1, 4'h4};
         7'b0010010: seg_decode = {1'b1, 4'h5};
         7'b0000010: seg_decode = {1'b1, 4'h6};
         7'b1111000: seg_decode = {1'b1, 4'h7};
         7'b0000000: seg_decode = {1'b1, 4'h8};
         7'b0010000: seg_decode = {1'b1, 4'h9};
         7'b0001000: seg_decode = {1'b1, 4'hA};
         7'b0000011: seg_decode = {1'b1, 4'hB};
         7'b1000110: seg_decode = {1'b1, 4'hC};
         7'b0100001: seg_decode = {1'b1, 4'hD};
         7'b0000110: seg_decode = {1'b1, 4'hE};
         7'b0001110: seg_decode = {1'b1, 4'hF};
         default:    seg_decode = {1'b0, 4'h0};
      endcase
   endfunction

   function automatic logic sel_single(input logic [N_DIG-1:0] sel);
      int n;
      n = 0;
      for (int i = 0; i < N_DIG; i++) n = n + int'(!sel[i]);
      return (n == 1);
   endfunction

   function automatic logic [IDX_W-1:0] sel_index(input logic [N_DIG-1:0] sel);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = N_DIG - 1; i >= 0; i--) idx = (!sel[i]) ? IDX_W'(i) : idx;
      return idx;
   endfunction

   logic [PAIR_W-1:0]  sync1_r, sync2_r, prev_r, cap_r;
   logic [7:0]         stab_cnt_r;
   state_t             state_r, state_s;
   logic               cap_load_s, sel_blank_s, settled_s;
   logic [4:0]         dec_s;
   logic               single_s, any_low_s, is_cap_s;
   logic               wr_s, blank_s, perr_s, serr_s;
   logic [IDX_W-1:0]   idx_s;
   logic [TO_W-1:0]    stale_cnt_r [N_DIG];
   logic [4*N_DIG-1:0] hex_data_r;
   logic [N_DIG-1:0]   digit_valid_r;
   logic               upd_stb_r, pat_err_r, sel_err_r;
   logic [IDX_W-1:0]   upd_idx_r;

   assign sel_blank_s = &sync2_r[PAIR_W-1:7];
   assign settled_s   = (stab_cnt_r == 8'(SETTLE_CYC));

   // Synchronisers (idle bus is all-ones) and the stability counter
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync1_r    <= '1;
         sync2_r    <= '1;
         prev_r     <= '1;
         stab_cnt_r <= 8'd0;
      end else begin
         sync1_r <= {seg_sel, seg_led};
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         if (sync2_r == prev_r) begin
            stab_cnt_r <= settled_s ? stab_cnt_r : stab_cnt_r + 8'd1;
         end else begin
            stab_cnt_r <= 8'd1;
         end
      end
   end

   // State register; cap_r keeps the pair proven stable during SETTLE
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_r <= ST_IDLE;
         cap_r   <= '1;
      end else begin
         state_r <= state_s;
         cap_r   <= cap_load_s ? prev_r : cap_r;
      end
   end

   // Next-state logic
   always_comb begin
      state_s    = state_r;
      cap_load_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!sel_blank_s) state_s = ST_SETTLE;
            else              state_s = ST_IDLE;
         end
         ST_SETTLE: begin
            if (sel_blank_s) begin
               state_s = ST_IDLE;
            end else if (settled_s) begin
               state_s    = ST_CAPTURE;
               cap_load_s = 1'b1;
            end else begin
               state_s = ST_SETTLE;
            end
         end
         ST_CAPTURE: state_s = ST_HOLD;
         ST_HOLD: begin
            if (sync2_r != cap_r) state_s = sel_blank_s ? ST_IDLE : ST_SETTLE;
            else                  state_s = ST_HOLD;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Capture classification; select errors mask pattern errors
   always_comb begin
      dec_s     = seg_decode(cap_r[6:0]);
      single_s  = sel_single(cap_r[PAIR_W-1:7]);
      any_low_s = ~&cap_r[PAIR_W-1:7];
      idx_s     = sel_index(cap_r[PAIR_W-1:7]);
      is_cap_s  = (state_r == ST_CAPTURE);
      wr_s      = is_cap_s & single_s & dec_s[4];
`ifdef SEG_SCAN_BLANK_EN
      blank_s   = is_cap_s & single_s & (cap_r[6:0] == 7'b1111111);
`else
      blank_s   = 1'b0;
`endif
      perr_s    = is_cap_s & single_s & ~dec_s[4] & ~blank_s;
      serr_s    = is_cap_s & ~single_s & any_low_s;
   end

   // Registered outputs and per-digit staleness; a write beats an expiry
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hex_data_r    <= '0;
         digit_valid_r <= '0;
         upd_stb_r     <= 1'b0;
         upd_idx_r     <= '0;
         pat_err_r     <= 1'b0;
         sel_err_r     <= 1'b0;
         for (int i = 0; i < N_DIG; i++) stale_cnt_r[i] <= '0;
      end else begin
         upd_stb_r <= wr_s | blank_s;
         pat_err_r <= perr_s;
         sel_err_r <= serr_s;
         upd_idx_r <= (wr_s | blank_s) ? idx_s : upd_idx_r;
         for (int i = 0; i < N_DIG; i++) begin
            if ((wr_s | blank_s) && (idx_s == IDX_W'(i))) begin
               stale_cnt_r[i] <= '0;
            end else if (stale_cnt_r[i] != TO_W'(TIMEOUT_CYC)) begin
               stale_cnt_r[i] <= stale_cnt_r[i] + TO_W'(1);
            end else begin
               stale_cnt_r[i] <= stale_cnt_r[i];
            end
            if (wr_s && (idx_s == IDX_W'(i))) begin
               hex_data_r[4*i +: 4] <= dec_s[3:0];
               digit_valid_r[i]     <= 1'b1;
            end else if ((blank_s | perr_s) && (idx_s == IDX_W'(i))) begin
               digit_valid_r[i] <= 1'b0;
            end else if (stale_cnt_r[i] == TO_W'(TIMEOUT_CYC)) begin
               digit_valid_r[i] <= 1'b0;
            end else begin
               digit_valid_r[i] <= digit_valid_r[i];
            end
         end
      end
   end

   assign hex_data    = hex_data_r;
   assign digit_valid = digit_valid_r;
   assign upd_stb     = upd_stb_r;
   assign upd_idx     = upd_idx_r;
   assign pat_err     = pat_err_r;
   assign sel_err     = sel_err_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus random windows against a digit-level model.
module tb_seg_scan_decoder;

   localparam int N_DIG       = 4;
   localparam int SETTLE_CYC  = 4;
   localparam int TIMEOUT_CYC = 400;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg_led = 7'h7F;
   logic [3:0]  seg_sel = 4'hF;
   logic [15:0] hex_data;
   logic [3:0]  digit_valid;
   logic        upd_stb;
   logic [1:0]  upd_idx;
   logic        pat_err;
   logic        sel_err;

   seg_scan_decoder #(
      .N_DIG       (N_DIG),
      .SETTLE_CYC  (SETTLE_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .sys_clk     (clk),
      .sys_rst     (rst),
      .seg_led     (seg_led),
      .seg_sel     (seg_sel),
      .hex_data    (hex_data),
      .digit_valid (digit_valid),
      .upd_stb     (upd_stb),
      .upd_idx     (upd_idx),
      .pat_err     (pat_err),
      .sel_err     (sel_err)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_upd, n_perr, n_serr;
   logic [1:0]  last_idx;
   logic [6:0]  pat_tab [16];
   logic [15:0] exp_hex;
   logic [3:0]  exp_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (upd_stb === 1'b1) begin
         n_upd++;
         last_idx = upd_idx;
      end
      if (pat_err === 1'b1) n_perr++;
      if (sel_err === 1'b1) n_serr++;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic clr();
      n_upd = 0; n_perr = 0; n_serr = 0; last_idx = 2'd0;
   endtask

   task automatic window(input logic [3:0] sel, input logic [6:0] led, input int h, input int gap);
      seg_sel = sel; seg_led = led;
      run(h);
      seg_sel = 4'hF; seg_led = 7'h7F;
      run(gap);
   endtask

   // Digit-level effect of one stable capture, straight from the decode rules
   task automatic model_window(input logic [3:0] sel, input logic [6:0] led,
                               output int e_upd, output int e_perr, output int e_serr, output int e_idx);
      int zeros, pos, k;
      e_upd = 0; e_perr = 0; e_serr = 0; e_idx = 0;
      zeros = 0; pos = 0; k = -1;
      for (int i = 0; i < 4; i++) if (!sel[i]) begin zeros++; pos = i; end
      for (int j = 0; j < 16; j++) if (pat_tab[j] == led) k = j;
      if (zeros > 1) e_serr = 1;
      else if (zeros == 1) begin
         e_idx = pos;
         if (k >= 0) begin
            exp_hex[4*pos +: 4] = 4'(k);
            exp_valid[pos] = 1'b1;
            e_upd = 1;
         end
`ifdef SEG_SCAN_BLANK_EN
         else if (led == 7'h7F) begin
            exp_valid[pos] = 1'b0;
            e_upd = 1;
         end
`endif
         else begin
            exp_valid[pos] = 1'b0;
            e_perr = 1;
         end
      end
   endtask

   initial begin
      int e_upd, e_perr, e_serr, e_idx, h, a, b, long_w;
      logic [3:0] sel;
      logic [6:0] led;
      pat_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      clr();

      // reset state
      run(3);
      check("reset_outputs", {hex_data, digit_valid, upd_stb, upd_idx, pat_err, sel_err}, 32'd0);
      rst = 1'b0;
      run(3);

      // basic capture on digit 1
      clr();
      window(4'b1101, 7'b0100100, 10, 4);
      check("basic_upd_count", n_upd, 1);
      check("basic_upd_idx", last_idx, 1);
      check("basic_nibble", hex_data[7:4], 4'h2);
      check("basic_valid", digit_valid, 4'b0010);

      // glitching pattern must not capture, then a stable F does
      clr();
      seg_sel = 4'b1110;
      for (int t = 0; t < 8; t++) begin
         seg_led = t[0] ? 7'b0110000 : 7'b0100100;
         run(2);
      end
      check("glitch_no_upd", n_upd, 0);
      check("glitch_no_perr", n_perr, 0);
      clr();
      window(4'b1110, 7'b0001110, 10, 4);
      check("glitch_then_f_upd", n_upd, 1);
      check("glitch_then_f_nibble", hex_data[3:0], 4'hF);

      // illegal pattern, then two selects low
      clr();
      window(4'b1110, 7'b1010101, 10, 4);
      check("perr_count", n_perr, 1);
      check("perr_no_upd", n_upd, 0);
      check("perr_valid", digit_valid, 4'b0010);
      check("perr_hex_held", hex_data[3:0], 4'hF);
      clr();
      window(4'b1100, 7'b0110000, 10, 4);
      check("serr_count", n_serr, 1);
      check("serr_no_perr", n_perr, 0);
      check("serr_no_upd", n_upd, 0);

      // all-off pattern on digit 2
      clr();
      window(4'b1011, 7'b1111111, 10, 4);
`ifdef SEG_SCAN_BLANK_EN
      check("blank_upd", n_upd, 1);
      check("blank_idx", last_idx, 2);
      check("blank_no_perr", n_perr, 0);
`else
      check("blank_perr", n_perr, 1);
      check("blank_no_upd", n_upd, 0);
`endif
      check("blank_valid2", digit_valid[2], 1'b0);

      // full scan 3,A,7,0 then let every digit go stale
      window(4'b1110, 7'b0110000, 8, 4);
      window(4'b1101, 7'b0001000, 8, 4);
      window(4'b1011, 7'b1111000, 8, 4);
      window(4'b0111, 7'b1000000, 8, 4);
      check("scan_hex", hex_data, 16'h07A3);
      check("scan_valid", digit_valid, 4'hF);
      run(TIMEOUT_CYC - 50);
      check("stale_not_yet", digit_valid, 4'hF);
      run(60);
      check("stale_valid", digit_valid, 4'h0);
      check("stale_hex_held", hex_data, 16'h07A3);

      // asynchronous reset in the middle of a settle window
      seg_sel = 4'b0111; seg_led = 7'b0010010;
      run(3);
      #2 rst = 1'b1;
      #1 check("async_reset_outputs", {hex_data, digit_valid, upd_stb, upd_idx, pat_err, sel_err}, 32'd0);
      seg_sel = 4'hF; seg_led = 7'h7F;
      run(2);
      rst = 1'b0;
      clr();
      run(12);
      check("after_reset_no_upd", n_upd, 0);

      // random windows against the model
      exp_hex = 16'h0000;
      exp_valid = 4'h0;
      for (int w = 0; w < 16; w++) begin
         if ($urandom_range(0, 9) < 8) begin
            sel = 4'hF;
            sel[$urandom_range(0, 3)] = 1'b0;
         end else begin
            a = $urandom_range(0, 3);
            b = (a + $urandom_range(1, 3)) % 4;
            sel = 4'hF; sel[a] = 1'b0; sel[b] = 1'b0;
         end
         case ($urandom_range(0, 9))
            0:       led = 7'h7F;
            1, 2:    led = 7'($urandom_range(0, 127));
            default: led = pat_tab[$urandom_range(0, 15)];
         endcase
         long_w = ($urandom_range(0, 3) != 0) ? 1 : 0;
         h = (long_w != 0) ? $urandom_range(SETTLE_CYC + 2, 12) : $urandom_range(1, SETTLE_CYC - 1);
         clr();
         window(sel, led, h, $urandom_range(4, 6));
         e_upd = 0; e_perr = 0; e_serr = 0; e_idx = 0;
         if (long_w != 0) model_window(sel, led, e_upd, e_perr, e_serr, e_idx);
         check("rnd_upd", n_upd, e_upd);
         check("rnd_perr", n_perr, e_perr);
         check("rnd_serr", n_serr, e_serr);
         if (e_upd != 0) check("rnd_idx", last_idx, e_idx);
         check("rnd_hex", hex_data, exp_hex);
         check("rnd_valid", digit_valid, exp_valid);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
